// File: rtl/mul_sequencer_pkg.sv
// Shared state codes and helpers for the multicycle core's multiply sequencer.
// The decode FSM and the controller that reads `state` both import these codes.
package mul_sequencer_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_FIX  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

  localparam int unsigned MUL_WIDTH_DEFAULT = 32;

  // The controller is held from the very cycle a request is accepted until DONE.
  function automatic logic mul_stall(input mul_state_e st, input logic start);
    logic accepting;
    accepting = (st == MUL_IDLE) || (st == MUL_DONE);
    return (accepting && start) || (st == MUL_RUN) || (st == MUL_FIX);
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Controller <-> multiply sequencer bundle: operands and request in, stall/result out.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  // Start is sampled only in IDLE/DONE; while Stall=1 the controller holds its state,
  // and Done pulses for exactly one cycle with ProdHi/ProdLo valid from that cycle on.
  logic             Start;
  logic             Signed;
  logic             AccEn;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] Acc;
  logic             Stall;
  logic             Done;
  logic [WIDTH-1:0] ProdLo;
  logic [WIDTH-1:0] ProdHi;
  logic [1:0]       state;

  modport master (
    output Start, Signed, AccEn, SrcA, SrcB, Acc,
    input  Stall, Done, ProdLo, ProdHi, state
  );

  modport slave (
    input  Start, Signed, AccEn, SrcA, SrcB, Acc,
    output Stall, Done, ProdLo, ProdHi, state
  );

endinterface

// File: rtl/mul_sequencer_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the upper
// half, then shift {carry, hi, lo} right by one.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, mcand_i} : {(WIDTH+1){1'b0}});
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_sequencer.sv
// Fixed-latency iterative multiply/accumulate sequencer (MUL/MLA/UMULL/SMULL).
// Operates on magnitudes and applies the sign and accumulate in a single FIX cycle.
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_ext;
  logic [2*WIDTH-1:0] p_full, fix_res;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .mcand_i(mcand_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    mag_a = (bus.Signed && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
    mag_b = (bus.Signed && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
    if (!bus.AccEn) begin
      acc_ext = '0;
    end else if (bus.Signed) begin
      acc_ext = {{WIDTH{bus.Acc[WIDTH-1]}}, bus.Acc};
    end else begin
      acc_ext = {{WIDTH{1'b0}}, bus.Acc};
    end

    p_full  = {hi_q, lo_q};
    fix_res = (neg_q ? -p_full : p_full) + acc_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    done_d    = 1'b0;

    case (state_q)
      MUL_IDLE, MUL_DONE: begin
        if (bus.Start) begin
          mcand_d = mag_a;
          lo_d    = mag_b;
          hi_d    = '0;
          cnt_d   = '0;
          neg_d   = bus.Signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
          acc_d   = acc_ext;
          state_d = MUL_RUN;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = MUL_FIX;
        end
      end
      MUL_FIX: begin
        prod_lo_d = fix_res[WIDTH-1:0];
        prod_hi_d = fix_res[2*WIDTH-1:WIDTH];
        done_d    = 1'b1;
        state_d   = MUL_DONE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MUL_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      done_q    <= done_d;
    end
  end

  assign bus.Stall  = mul_stall(state_q, bus.Start);
  assign bus.Done   = done_q;
  assign bus.ProdLo = prod_lo_q;
  assign bus.ProdHi = prod_hi_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: table of operand/result vectors plus hand-written
// sequences for re-pulsed Start, back-to-back operations and mid-run reset.
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(W)) bus ();
  mul_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   acc;
    logic           sgn;
    logic           acc_en;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  vec_t vecs[12];
  logic [2*W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called mid-cycle; the current cycle is cycle 0. Returns mid-cycle in the Done cycle.
  task automatic run_op(input vec_t v, input int restart_cyc);
    int cyc;
    int stall_err;
    bit seen;
    logic [2*W-1:0] e;
    exp_q.push_back(v.exp);
    bus.Start  = 1'b1;
    bus.SrcA   = v.a;
    bus.SrcB   = v.b;
    bus.Acc    = v.acc;
    bus.Signed = v.sgn;
    bus.AccEn  = v.acc_en;
    #1;
    check({v.name, "_stall_c0"}, 64'(bus.Stall), 64'd1);
    cyc = 0;
    stall_err = 0;
    seen = 1'b0;
    while (!seen && cyc < LAT + 6) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.Start  = 1'b0;
        bus.SrcA   = $urandom;
        bus.SrcB   = $urandom;
        bus.Acc    = $urandom;
        bus.Signed = 1'($urandom_range(0, 1));
        bus.AccEn  = 1'($urandom_range(0, 1));
      end
      if (cyc == restart_cyc) bus.Start = 1'b1;
      else if (cyc == restart_cyc + 1) bus.Start = 1'b0;
      #1;
      if (bus.Done === 1'b1) seen = 1'b1;
      else if (bus.Stall !== 1'b1) stall_err++;
    end
    e = exp_q.pop_front();
    check({v.name, "_latency"}, 64'(cyc), 64'(LAT));
    check({v.name, "_stall_run"}, 64'(stall_err), 64'd0);
    check({v.name, "_state_done"}, 64'(bus.state), 64'(MUL_DONE));
    check({v.name, "_prod"}, {bus.ProdHi, bus.ProdLo}, e);
  endtask

  // From mid-Done cycle with no new request: Done must drop, state return to IDLE,
  // and the result must be held.
  task automatic idle_after(input vec_t v);
    check({v.name, "_stall_done"}, 64'(bus.Stall), 64'd0);
    @(negedge clk);
    #1;
    check({v.name, "_done_pulse"}, 64'(bus.Done), 64'd0);
    check({v.name, "_idle"}, 64'(bus.state), 64'(MUL_IDLE));
    check({v.name, "_hold"}, {bus.ProdHi, bus.ProdLo}, v.exp);
  endtask

  initial begin
    vec_t v;
    int done_cnt;
    vecs[0]  = '{32'd7,        32'd6,        32'd0,        1'b0, 1'b0, 64'd42,                 "u_7x6"};
    vecs[1]  = '{32'hFFFFFFFD, 32'd5,        32'd0,        1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFF1, "s_m3x5"};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 64'hFFFFFFFE_00000001, "u_max"};
    vecs[3]  = '{32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b0, 64'h40000000_00000000, "s_minxmin"};
    vecs[4]  = '{32'd10,       32'd10,       32'd5,        1'b0, 1'b1, 64'd105,                "u_mla"};
    vecs[5]  = '{32'd2,        32'd3,        32'hFFFFFFF0, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFF6, "s_mla_neg"};
    vecs[6]  = '{32'd0,        32'd12345,    32'd0,        1'b0, 1'b0, 64'd0,                  "u_zero"};
    vecs[7]  = '{32'd1,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b1, 64'h00000001_00000000, "u_acc_zext"};
    vecs[8]  = '{32'd3,        32'd3,        32'd100,      1'b0, 1'b0, 64'd9,                  "acc_disabled"};
    vecs[9]  = '{32'hFFFFFFF9, 32'hFFFFFFFA, 32'd0,        1'b1, 1'b0, 64'd42,                 "s_negxneg"};
    vecs[10] = '{32'hFFFFFFFD, 32'd5,        32'd0,        1'b0, 1'b0, 64'h00000004_FFFFFFF1, "u_bigx5"};
    vecs[11] = '{32'h80000000, 32'd3,        32'd0,        1'b1, 1'b0, 64'hFFFFFFFE_80000000, "s_minx3"};

    reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Signed = 1'b0;
    bus.AccEn  = 1'b0;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    bus.Acc    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", 64'(bus.state), 64'(MUL_IDLE));
    check("reset_stall", 64'(bus.Stall), 64'd0);
    check("reset_done", 64'(bus.Done), 64'd0);
    check("reset_prod", {bus.ProdHi, bus.ProdLo}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], -1);
      idle_after(vecs[i]);
    end

    // Start re-pulsed in RUN is ignored.
    v = '{32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 64'd42, "restart_ignored"};
    run_op(v, 10);
    idle_after(v);

    // Back-to-back: new request during DONE; second Done 34 cycles later (cycle 68).
    v = '{32'd11, 32'd13, 32'd0, 1'b0, 1'b0, 64'd143, "b2b_first"};
    run_op(v, -1);
    v = '{32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 64'd12, "b2b_second"};
    run_op(v, -1);
    idle_after(v);

    // Reset mid-RUN discards the operation.
    bus.Start  = 1'b1;
    bus.SrcA   = 32'd9;
    bus.SrcB   = 32'd9;
    bus.Signed = 1'b0;
    bus.AccEn  = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.Start = 1'b0;
      if (cyc == 15) reset = 1'b1;
      if (cyc == 16) reset = 1'b0;
    end
    #1;
    check("rst_mid_state", 64'(bus.state), 64'(MUL_IDLE));
    check("rst_mid_stall", 64'(bus.Stall), 64'd0);
    check("rst_mid_done", 64'(bus.Done), 64'd0);
    check("rst_mid_prodlo", 64'(bus.ProdLo), 64'd0);
    check("rst_mid_prodhi", 64'(bus.ProdHi), 64'd0);
    done_cnt = 0;
    repeat (LAT + 6) begin
      @(negedge clk);
      #1;
      if (bus.Done === 1'b1) done_cnt++;
    end
    check("rst_mid_no_done", 64'(done_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Iterative radix-2 shift-add multiply/accumulate sequencer for the multicycle ARM core.
- The main controller hands it operands read from the register file. It runs a fixed-latency sequence and raises Stall so the controller FSM holds its current state (no PCWrite/RegWrite) until the result is ready.
- Supports MUL/MLA (low word) and UMULL/SMULL (full 64 bit).

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits; iteration count = WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high; returns block to IDLE.
Start  input  1  request; sampled only in IDLE or DONE.
Signed  input  1  1 = two's-complement operands (SMULL), 0 = unsigned.
AccEn  input  1  1 = add Acc to product (MLA).
SrcA  input  WIDTH  multiplicand (Rn/Rm value from datapath).
SrcB  input  WIDTH  multiplier.
Acc  input  WIDTH  accumulate operand.
Stall  output  1  hold request to controller.
Done  output  1  one-cycle result-valid pulse.
ProdLo  output  WIDTH  result bits [WIDTH-1:0].
ProdHi  output  WIDTH  result bits [2*WIDTH-1:WIDTH].
state  output  2  current FSM state, for debug visibility.

Behaviour:
- Reset: state=IDLE, Stall=0, Done=0, ProdLo=0, ProdHi=0, iteration counter=0, internal sign flag=0.
- States: IDLE(0), RUN(1), FIX(2), DONE(3).
- IDLE, Start=1 (cycle 0):
  - Latch |SrcA| and |SrcB| (magnitude only when Signed=1, else raw).
  - Latch neg = Signed & (SrcA[msb]^SrcB[msb]).
  - Latch Acc, extended to 2*WIDTH: sign-extended if Signed, zero-extended otherwise; zero if AccEn=0.
  - Clear the product register and counter; go to RUN.
- RUN, one iteration per cycle:
  - If multiplier LSB=1, add multiplicand into the upper half with a WIDTH+1-bit carry.
  - Shift {carry, upper, multiplier} right by 1.
  - Counter increments; after WIDTH iterations go to FIX (RUN lasts exactly WIDTH cycles, 1..WIDTH).
- FIX (cycle WIDTH+1):
  - result = (neg ? -P : P) + AccExt, modulo 2^(2*WIDTH).
  - Load into ProdHi/ProdLo; go to DONE.
- DONE (cycle WIDTH+2):
  - Done=1 for this cycle only.
  - Start=1 begins a new operation (back-to-back, goes to RUN next cycle with new latches).
  - Otherwise go to IDLE.
- Stall = (state==IDLE & Start) | state==RUN | state==FIX | (state==DONE & Start). This is combinational, so the controller is held from the cycle of Start.
- Total latency: Start sampled at cycle 0 -> Done at cycle WIDTH+2 (34 for WIDTH=32).
- ProdHi/ProdLo hold the last result through IDLE until the next FIX overwrites them. Input changes after cycle 0 have no effect.
- Start while in RUN or FIX is ignored; there is no queuing.
- Reset asserted in any state, including mid-RUN: next cycle is IDLE with all outputs at reset values; the partial product is discarded.
- Edge cases:
  - Signed most-negative operand (0x80000000): its magnitude 0x80000000 is correct as an unsigned WIDTH-bit value; no overflow special case.
  - Zero operand: normal 32-cycle sequence, no early exit, so latency is fixed.

Decomposition:
- Shared package (same one holding the decode FSM state codes): MUL_IDLE/MUL_RUN/MUL_FIX/MUL_DONE 2-bit constants.
- One sub-module, mul_step: combinational single iteration. It takes {hi, lo, multiplicand} and returns the shifted {hi, lo}; instantiated once in the RUN path.
- Counter, latches and FSM stay in mul_sequencer.

Test Plan:
- Unsigned: SrcA=7, SrcB=6, Signed=0, AccEn=0, Start at cycle 0 -> Stall=1 on cycles 0..33, Done=1 only at cycle 34, ProdHi=0, ProdLo=42.
- Signed: SrcA=0xFFFFFFFD (-3), SrcB=5, Signed=1 -> {ProdHi,ProdLo}=0xFFFFFFFF_FFFFFFF1.
- Extremes:
  - 0xFFFFFFFF x 0xFFFFFFFF unsigned -> 0xFFFFFFFE_00000001.
  - 0x80000000 x 0x80000000 signed -> 0x40000000_00000000.
- Accumulate: SrcA=10, SrcB=10, Acc=5, AccEn=1, Signed=0 -> ProdLo=105, ProdHi=0.
- Signed accumulate: SrcA=2, SrcB=3, Acc=0xFFFFFFF0 (-16), Signed=1 -> 0xFFFFFFFF_FFFFFFF6.
- Control sequencing:
  - Start pulsed again at cycle 10 (RUN) -> ignored; Done still at 34 with the original result.
  - Start held at cycle 34 (DONE) with 3x4 -> Stall stays 1, second Done at cycle 68 with ProdLo=12.
  - reset at cycle 15 -> cycle 16: state=0, Stall=0, Done=0, ProdLo=ProdHi=0, and no Done appears afterwards.
